// File: rtl/regfile_pkg.sv
// Shared helpers for the multi-port register file: address-width helper and the hardwired-zero index.
package regfile_pkg;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback-facing bundle of the register file: read ports, write ports, reserve and busy vector.
interface regfile_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  import regfile_pkg::*;
  localparam int AW = addr_w(NREGS);

  logic [NUM_RD-1:0]      rd_en;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic [NREGS-1:0]       busy_vec;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_rd_port.sv
// One registered read port: selects array data, same-cycle write data or zero, plus next-state busy.
// Latency: 1 cycle from rd_en to rd_data/rd_busy; outputs hold while rd_en is low.
// Backpressure: none; reads are never stalled by writes.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NUM_WR    = 1,
  parameter int ZERO_REG0 = 1,
  parameter int BYPASS    = 1,
  parameter int AW        = addr_w(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  input  logic [NREGS*XLEN-1:0]  regs_flat,
  input  logic [NREGS-1:0]       busy_nxt,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  output logic [XLEN-1:0]        rd_data,
  output logic                   rd_busy
);

  logic [XLEN-1:0] data_sel;
  logic            busy_sel;

  always_comb begin
    data_sel = regs_flat[rd_addr*XLEN +: XLEN];
    busy_sel = busy_nxt[rd_addr];
    // Ascending scan so the highest-numbered matching write port wins, as in the array.
    if (BYPASS != 0) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr) begin
          data_sel = wr_data[j*XLEN +: XLEN];
        end
      end
    end
    if (ZERO_REG0 != 0 && rd_addr == AW'(REG_ZERO)) begin
      data_sel = '0;
      busy_sel = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      rd_busy <= 1'b0;
    end else if (rd_en) begin
      rd_data <= data_sel;
      rd_busy <= busy_sel;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard (decode reserves, writeback clears).
// Latency: writes and reserves take effect at the edge; reads return post-edge state 1 cycle after rd_en.
// Backpressure: none; all ports accept every cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1,
  parameter int ZERO_REG0 = 1,
  parameter int BYPASS    = 1
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  localparam int AW = addr_w(NREGS);

  logic [XLEN-1:0]       regs [NREGS];
  logic [NREGS*XLEN-1:0] regs_flat;
  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_nxt;

  // Later write ports overwrite earlier ones within the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en[j] &&
            !(ZERO_REG0 != 0 && bus.wr_addr[j*AW +: AW] == AW'(REG_ZERO))) begin
          regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_flat
    assign regs_flat[r*XLEN +: XLEN] = regs[r];
  end

  // Reserve applied after write-clears so a new producer keeps the register busy.
  always_comb begin
    busy_nxt = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (bus.wr_en[j]) begin
        busy_nxt[bus.wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (bus.rsv_en) begin
      busy_nxt[bus.rsv_addr] = 1'b1;
    end
    if (ZERO_REG0 != 0) begin
      busy_nxt[REG_ZERO] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign bus.busy_vec = busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .XLEN      (XLEN),
      .NREGS     (NREGS),
      .NUM_WR    (NUM_WR),
      .ZERO_REG0 (ZERO_REG0),
      .BYPASS    (BYPASS),
      .AW        (AW)
    ) u_rd (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (bus.rd_en[i]),
      .rd_addr   (bus.rd_addr[i*AW +: AW]),
      .regs_flat (regs_flat),
      .busy_nxt  (busy_nxt),
      .wr_en     (bus.wr_en),
      .wr_addr   (bus.wr_addr),
      .wr_data   (bus.wr_data),
      .rd_data   (bus.rd_data[i*XLEN +: XLEN]),
      .rd_busy   (bus.rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (2 read, 2 write ports, x0 hardwired, bypass on): directed table plus random vs. model.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) bus ();

  regfile_mp #(
    .XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG0(1), .BYPASS(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [1:0]  t_we;
  logic [4:0]  t_wa [2];
  logic [31:0] t_wd [2];
  logic        t_rsv;
  logic [4:0]  t_rsa;
  logic [1:0]  t_re;
  logic [4:0]  t_ra [2];

  assign bus.wr_en    = t_we;
  assign bus.wr_addr  = {t_wa[1], t_wa[0]};
  assign bus.wr_data  = {t_wd[1], t_wd[0]};
  assign bus.rsv_en   = t_rsv;
  assign bus.rsv_addr = t_rsa;
  assign bus.rd_en    = t_re;
  assign bus.rd_addr  = {t_ra[1], t_ra[0]};

  // Architectural model: array of registers, array of busy bits, held read outputs.
  logic [31:0] m_regs [32];
  logic        m_busy [32];
  logic [31:0] m_rd_data [2];
  logic        m_rd_busy [2];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      m_rd_data[i] = '0;
      m_rd_busy[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int j = 0; j < 2; j++)
      if (t_we[j] && t_wa[j] != 5'd0) m_regs[t_wa[j]] = t_wd[j];
    for (int j = 0; j < 2; j++)
      if (t_we[j]) m_busy[t_wa[j]] = 1'b0;
    if (t_rsv && t_rsa != 5'd0) m_busy[t_rsa] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (t_re[i]) begin
        m_rd_data[i] = m_regs[t_ra[i]];
        m_rd_busy[i] = m_busy[t_ra[i]];
      end
    end
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic idle();
    t_we = '0; t_wa[0] = '0; t_wa[1] = '0; t_wd[0] = '0; t_wd[1] = '0;
    t_rsv = 1'b0; t_rsa = '0; t_re = '0; t_ra[0] = '0; t_ra[1] = '0;
  endtask

  // Inputs are set between edges; outputs sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv;
    logic [4:0]  rsa;
    logic [4:0]  ra;
    logic [31:0] exp_d;
    logic        exp_b;
    logic [31:0] exp_bv;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{"wr_r3",      2'b01, 5'd3,  32'h0000_1234, 5'd0,  32'h0,  1'b0, 5'd0,  5'd1,  32'h0,          1'b0, 32'h0};
    vecs[1] = '{"rd_r3",      2'b00, 5'd0,  32'h0,         5'd0,  32'h0,  1'b0, 5'd0,  5'd3,  32'h0000_1234,  1'b0, 32'h0};
    vecs[2] = '{"bypass_r7",  2'b01, 5'd7,  32'hA5A5_A5A5, 5'd0,  32'h0,  1'b0, 5'd0,  5'd7,  32'hA5A5_A5A5,  1'b0, 32'h0};
    vecs[3] = '{"x0",         2'b01, 5'd0,  32'hFFFF_FFFF, 5'd0,  32'h0,  1'b1, 5'd0,  5'd0,  32'h0,          1'b0, 32'h0};
    vecs[4] = '{"rsv_r9",     2'b00, 5'd0,  32'h0,         5'd0,  32'h0,  1'b1, 5'd9,  5'd9,  32'h0,          1'b1, 32'h0000_0200};
    vecs[5] = '{"wr_r9",      2'b01, 5'd9,  32'h99,        5'd0,  32'h0,  1'b0, 5'd0,  5'd9,  32'h99,         1'b0, 32'h0};
    vecs[6] = '{"rsv_wr_r9",  2'b01, 5'd9,  32'h55,        5'd0,  32'h0,  1'b1, 5'd9,  5'd9,  32'h55,         1'b1, 32'h0000_0200};
    vecs[7] = '{"collide_r4", 2'b11, 5'd4,  32'h11,        5'd4,  32'h22, 1'b0, 5'd0,  5'd4,  32'h22,         1'b0, 32'h0000_0200};
    vecs[8] = '{"rd_r4",      2'b00, 5'd0,  32'h0,         5'd0,  32'h0,  1'b0, 5'd0,  5'd4,  32'h22,         1'b0, 32'h0000_0200};
    vecs[9] = '{"p1_rsv_r12", 2'b10, 5'd0,  32'h0,         5'd12, 32'h77, 1'b1, 5'd12, 5'd12, 32'h77,         1'b1, 32'h0000_1200};

    idle();
    model_reset();

    #3;
    chk("reset_rd_data0", bus.rd_data[31:0], 32'h0);
    chk("reset_rd_data1", bus.rd_data[63:32], 32'h0);
    chk("reset_rd_busy", {30'h0, bus.rd_busy}, 32'h0);
    chk("reset_busy_vec", bus.busy_vec, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted between edges clears outputs at once and wipes the array.
    @(negedge clk);
    t_we = 2'b01; t_wa[0] = 5'd5; t_wd[0] = 32'hDEAD_BEEF;
    t_rsv = 1'b1; t_rsa = 5'd6; t_re = 2'b01; t_ra[0] = 5'd5;
    cycle();
    chk("pre_rst_rd_r5", bus.rd_data[31:0], 32'hDEAD_BEEF);
    chk("pre_rst_busy_vec", bus.busy_vec, 32'h0000_0040);
    idle();
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_data0", bus.rd_data[31:0], 32'h0);
    chk("mid_rst_busy_vec", bus.busy_vec, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    t_re = 2'b01; t_ra[0] = 5'd5;
    cycle();
    chk("post_rst_rd_r5", bus.rd_data[31:0], 32'h0);

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      idle();
      t_we = vecs[k].we;
      t_wa[0] = vecs[k].wa0; t_wd[0] = vecs[k].wd0;
      t_wa[1] = vecs[k].wa1; t_wd[1] = vecs[k].wd1;
      t_rsv = vecs[k].rsv; t_rsa = vecs[k].rsa;
      t_re = 2'b01; t_ra[0] = vecs[k].ra;
      cycle();
      chk({vecs[k].name, "_data"}, bus.rd_data[31:0], vecs[k].exp_d);
      chk({vecs[k].name, "_busy"}, {31'h0, bus.rd_busy[0]}, {31'h0, vecs[k].exp_b});
      chk({vecs[k].name, "_busy_vec"}, bus.busy_vec, vecs[k].exp_bv);
      chk({vecs[k].name, "_p1_hold"}, bus.rd_data[63:32], 32'h0);
    end

    // Random traffic; narrow address range half the time to force collisions and bypass hits.
    for (int n = 0; n < 400; n++) begin
      int hi;
      @(negedge clk);
      hi = ($urandom_range(0, 1) == 0) ? 7 : 31;
      t_we = 2'($urandom_range(0, 3));
      for (int j = 0; j < 2; j++) begin
        t_wa[j] = 5'($urandom_range(0, hi));
        t_wd[j] = $urandom;
        t_ra[j] = 5'($urandom_range(0, hi));
      end
      t_rsv = ($urandom_range(0, 2) == 0);
      t_rsa = 5'($urandom_range(0, hi));
      t_re = 2'($urandom_range(0, 3));
      cycle();
      chk("rand_rd_data0", bus.rd_data[31:0], m_rd_data[0]);
      chk("rand_rd_data1", bus.rd_data[63:32], m_rd_data[1]);
      chk("rand_rd_busy", {30'h0, bus.rd_busy}, {30'h0, m_rd_busy[1], m_rd_busy[0]});
      chk("rand_busy_vec", bus.busy_vec, model_busy_vec());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
